sram_seq: RTL

SRAM_SEQ -- requirements
Module: sram_seq

---
 rtl/sram_seq_if.sv | 24 ++
 rtl/sram_seq.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/sram_seq_if.sv
// Request/response handshake between a bus master and the SRAM sequencer.
// The master holds a request until req_wait is seen low at a rising edge.
interface sram_seq_if #(
    parameter int ADDR_W = 18
);
    logic [ADDR_W-1:0] req_addr;
    logic              req_read;
    logic              req_write;
    logic [31:0]       req_wdata;
    logic [3:0]        req_be;
    logic              req_wait;
    logic              res_valid;
    logic [31:0]       res_data;

    modport master (
        output req_addr, req_read, req_write, req_wdata, req_be,
        input  req_wait, res_valid, res_data
    );

    modport slave (
        input  req_addr, req_read, req_write, req_wdata, req_be,
        output req_wait, res_valid, res_data
    );
endinterface

// File: rtl/sram_seq.sv
// Single-access asynchronous SRAM sequencer: timed read / write-with-hold
// cycles followed by an optional idle turnaround, all SRAM pins registered.
module sram_seq #(
    parameter int ADDR_W  = 18,
    parameter int WAIT_RD = 2,
    parameter int WAIT_WR = 2,
    parameter int TURN    = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    sram_seq_if.slave         bus,
    output logic [ADDR_W-1:0] sram_a,
    inout  wire  [31:0]       sram_d,
    output logic              sram_cs_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic [3:0]        sram_be_n
);
    typedef enum logic [2:0] {ST_IDLE, ST_RD, ST_WR, ST_WHOLD, ST_TURN} state_e;

    localparam logic [3:0] RD_LD   = 4'(WAIT_RD - 1);
    localparam logic [3:0] WR_LD   = 4'(WAIT_WR - 1);
    localparam logic [2:0] TURN_LD = (TURN > 0) ? 3'(TURN - 1) : 3'd0;
    localparam state_e     POST_ST = (TURN > 0) ? ST_TURN : ST_IDLE;

    state_e            state_q, state_d;
    logic [3:0]        wait_q, wait_d;
    logic [2:0]        turn_q, turn_d;
    logic [ADDR_W-1:0] a_q, a_d;
    logic [31:0]       dq_q, dq_d;
    logic              dq_oe_q, dq_oe_d;
    logic              cs_n_q, cs_n_d;
    logic              oe_n_q, oe_n_d;
    logic              we_n_q, we_n_d;
    logic [3:0]        be_n_q, be_n_d;
    logic              res_valid_q, res_valid_d;
    logic [31:0]       res_data_q, res_data_d;
    logic              accept;
    logic              rd_last;

    assign accept  = (state_q == ST_IDLE) && (bus.req_read || bus.req_write);
    assign rd_last = (state_q == ST_RD) && (wait_q == 4'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            wait_q      <= 4'd0;
            turn_q      <= 3'd0;
            a_q         <= '0;
            dq_oe_q     <= 1'b0;
            cs_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
            we_n_q      <= 1'b1;
            be_n_q      <= 4'b1111;
            res_valid_q <= 1'b0;
            res_data_q  <= 32'd0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            turn_q      <= turn_d;
            a_q         <= a_d;
            dq_oe_q     <= dq_oe_d;
            cs_n_q      <= cs_n_d;
            oe_n_q      <= oe_n_d;
            we_n_q      <= we_n_d;
            be_n_q      <= be_n_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
        end
    end

    // Write data is only qualified by dq_oe_q, so it needs no reset.
    always_ff @(posedge clk) begin
        dq_q <= dq_d;
    end

    // A simultaneous read+write request takes the write and drops the read.
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        turn_d  = turn_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.req_write) begin
                    state_d = ST_WR;
                    wait_d  = WR_LD;
                end else if (bus.req_read) begin
                    state_d = ST_RD;
                    wait_d  = RD_LD;
                end
            end
            ST_RD: begin
                if (wait_q == 4'd0) begin
                    state_d = POST_ST;
                    turn_d  = TURN_LD;
                end else begin
                    wait_d = wait_q - 4'd1;
                end
            end
            ST_WR: begin
                if (wait_q == 4'd0) state_d = ST_WHOLD;
                else                wait_d  = wait_q - 4'd1;
            end
            ST_WHOLD: begin
                state_d = POST_ST;
                turn_d  = TURN_LD;
            end
            ST_TURN: begin
                if (turn_q == 3'd0) state_d = ST_IDLE;
                else                turn_d  = turn_q - 3'd1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Pin values are decoded from the next state so every pin is a flop output.
    always_comb begin
        a_d         = a_q;
        dq_d        = dq_q;
        be_n_d      = 4'b1111;
        cs_n_d      = 1'b1;
        oe_n_d      = 1'b1;
        we_n_d      = 1'b1;
        dq_oe_d     = 1'b0;
        res_valid_d = rd_last;
        res_data_d  = rd_last ? sram_d : res_data_q;
        if (accept) begin
            a_d  = bus.req_addr;
            dq_d = bus.req_wdata;
        end
        case (state_d)
            ST_RD: begin
                cs_n_d = 1'b0;
                oe_n_d = 1'b0;
                be_n_d = 4'b0000;
            end
            ST_WR: begin
                cs_n_d  = 1'b0;
                we_n_d  = 1'b0;
                dq_oe_d = 1'b1;
                be_n_d  = accept ? ~bus.req_be : be_n_q;
            end
            ST_WHOLD: begin
                cs_n_d  = 1'b0;
                dq_oe_d = 1'b1;
                be_n_d  = be_n_q;
            end
            default: ;
        endcase
    end

    assign bus.req_wait  = (state_q != ST_IDLE);
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign sram_a        = a_q;
    assign sram_cs_n     = cs_n_q;
    assign sram_oe_n     = oe_n_q;
    assign sram_we_n     = we_n_q;
    assign sram_be_n     = be_n_q;
    assign sram_d        = dq_oe_q ? dq_q : 32'hzzzz_zzzz;
endmodule
